// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Drives the PC register's write enable and next value for the multi-cycle
//   16-bit core. Each fetch produces one sequential-increment write. One
//   completion/redirect event per instruction may produce a second write
//   (taken branch, jump, call, return). A circular return-address stack
//   serves call/return.
//
// Ports
//   CLK, RST_N            clock, async active-low reset
//   input_PS_fetch        request sequential increment (IDLE only)
//   input_PS_curPC        current PC register value
//   input_PS_stall        freeze everything, suppress writes
//   input_PS_seqDone      instruction finished, no redirect
//   input_PS_brValid/brTaken/target   branch resolution and target
//   input_PS_jmpValid/link            jump, optionally a call (push curPC)
//   input_PS_retValid     return, target popped from the RAS
//   output_PS_PCWrite     registered single-cycle PC write pulse
//   output_PS_newPC       registered next PC, holds between pulses
//   output_PS_rasEmpty/rasFull        RAS occupancy flags
//   output_PS_err         sticky RAS overflow/underflow flag
module pc_sequencer #(
    parameter int          RAS_DEPTH = 4,
    parameter logic [15:0] INC       = 16'd2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        input_PS_fetch,
    input  logic [15:0] input_PS_curPC,
    input  logic        input_PS_stall,
    input  logic        input_PS_seqDone,
    input  logic        input_PS_brValid,
    input  logic        input_PS_brTaken,
    input  logic [15:0] input_PS_target,
    input  logic        input_PS_jmpValid,
    input  logic        input_PS_link,
    input  logic        input_PS_retValid,
    output logic        output_PS_PCWrite,
    output logic [15:0] output_PS_newPC,
    output logic        output_PS_rasEmpty,
    output logic        output_PS_rasFull,
    output logic        output_PS_err
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic {IDLE, DECIDE} state_t;

    state_t          state, state_nxt;
    logic            pc_write, pcw_nxt;
    logic [15:0]     new_pc, npc_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;          // next free slot
    logic [PW-1:0]   ptr_inc, ptr_dec;
    logic            err, err_nxt;
    logic            push;
    logic            full, empty;
    logic [15:0]     ras [RAS_DEPTH];

    // Depth need not be a power of two, so wrap explicitly.
    assign ptr_inc = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign ptr_dec = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
    assign full    = (cnt == CW'(RAS_DEPTH));
    assign empty   = (cnt == '0);

    always_comb begin
        state_nxt = state;
        pcw_nxt   = 1'b0;
        npc_nxt   = new_pc;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        err_nxt   = err;
        push      = 1'b0;
        if (!input_PS_stall) begin
            case (state)
                IDLE: begin
                    if (input_PS_fetch) begin
                        pcw_nxt   = 1'b1;
                        npc_nxt   = input_PS_curPC + INC;
                        state_nxt = DECIDE;
                    end
                end
                DECIDE: begin
                    // The cycle carrying the increment pulse is skipped: curPC
                    // only becomes the incremented value after that pulse
                    // lands, and this keeps the two pulses non-adjacent.
                    if (!pc_write) begin
                        if (input_PS_retValid) begin
                            state_nxt = IDLE;
                            if (!empty) begin
                                pcw_nxt = 1'b1;
                                npc_nxt = ras[ptr_dec];
                                ptr_nxt = ptr_dec;
                                cnt_nxt = cnt - 1'b1;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end else if (input_PS_jmpValid) begin
                            state_nxt = IDLE;
                            pcw_nxt   = 1'b1;
                            npc_nxt   = input_PS_target;
                            if (input_PS_link) begin
                                // Full push overwrites the oldest entry,
                                // which is exactly the slot at ptr.
                                push    = 1'b1;
                                ptr_nxt = ptr_inc;
                                if (full) err_nxt = 1'b1;
                                else      cnt_nxt = cnt + 1'b1;
                            end
                        end else if (input_PS_brValid) begin
                            state_nxt = IDLE;
                            if (input_PS_brTaken) begin
                                pcw_nxt = 1'b1;
                                npc_nxt = input_PS_target;
                            end
                        end else if (input_PS_seqDone) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            pc_write <= 1'b0;
            new_pc   <= 16'h0000;
            cnt      <= '0;
            ptr      <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_write <= pcw_nxt;
            new_pc   <= npc_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            err      <= err_nxt;
        end
    end

    // Entry storage needs no reset; occupancy lives in cnt.
    always_ff @(posedge CLK) begin
        if (push) ras[ptr] <= input_PS_curPC;
    end

    assign output_PS_PCWrite  = pc_write;
    assign output_PS_newPC    = new_pc;
    assign output_PS_rasEmpty = empty;
    assign output_PS_rasFull  = full;
    assign output_PS_err      = err;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan scenarios plus a
// randomized run, every cycle compared against an instruction-level model.
module tb_pc_sequencer;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        fetch = 0, stall = 0, seq = 0, bv = 0, bt = 0, jv = 0, link = 0, rv = 0;
    logic [15:0] cur = '0, tgt = '0;
    logic        PCWrite, rasEmpty, rasFull, err;
    logic [15:0] newPC;

    int n_chk = 0, n_fail = 0;

    // model state: phase 0 = idle, 1 = increment pulse in flight, 2 = awaiting event
    int          m_phase;
    bit          m_pcw, m_err;
    logic [15:0] m_npc;
    logic [15:0] m_ras[$];

    pc_sequencer #(.RAS_DEPTH(DEPTH), .INC(16'd2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .input_PS_fetch(fetch), .input_PS_curPC(cur), .input_PS_stall(stall),
        .input_PS_seqDone(seq), .input_PS_brValid(bv), .input_PS_brTaken(bt),
        .input_PS_target(tgt), .input_PS_jmpValid(jv), .input_PS_link(link),
        .input_PS_retValid(rv),
        .output_PS_PCWrite(PCWrite), .output_PS_newPC(newPC),
        .output_PS_rasEmpty(rasEmpty), .output_PS_rasFull(rasFull), .output_PS_err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pcw = 0; m_npc = 16'h0000; m_err = 0;
        m_ras.delete();
    endtask

    task automatic model_step();
        m_pcw = 0;
        if (m_phase == 1) begin
            m_phase = 2;
        end else if (!stall) begin
            if (m_phase == 0) begin
                if (fetch) begin m_pcw = 1; m_npc = cur + 16'd2; m_phase = 1; end
            end else if (rv) begin
                if (m_ras.size() > 0) begin m_pcw = 1; m_npc = m_ras.pop_back(); end
                else m_err = 1;
                m_phase = 0;
            end else if (jv) begin
                m_pcw = 1; m_npc = tgt;
                if (link) begin
                    m_ras.push_back(cur);
                    if (m_ras.size() > DEPTH) begin void'(m_ras.pop_front()); m_err = 1; end
                end
                m_phase = 0;
            end else if (bv) begin
                if (bt) begin m_pcw = 1; m_npc = tgt; end
                m_phase = 0;
            end else if (seq) begin
                m_phase = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST_N) model_step();
        #1;
        chk("pcwrite",   16'(PCWrite),  16'(m_pcw));
        chk("newpc",     newPC,         m_npc);
        chk("ras_empty", 16'(rasEmpty), 16'(m_ras.size() == 0));
        chk("ras_full",  16'(rasFull),  16'(m_ras.size() == DEPTH));
        chk("err",       16'(err),      16'(m_err));
    endtask

    task automatic clear_in();
        fetch = 0; stall = 0; seq = 0; bv = 0; bt = 0; jv = 0; link = 0; rv = 0;
    endtask

    // fetch at pc, check the increment pulse, then let the pulse cycle pass
    task automatic fetch_instr(input logic [15:0] pc);
        clear_in(); fetch = 1; cur = pc;
        tick();
        fetch = 0;
        chk("inc_pulse", 16'(PCWrite), 16'h1);
        chk("inc_value", newPC, pc + 16'd2);
        cur = pc + 16'd2;
        tick();
        chk("no_adjacent", 16'(PCWrite), 16'h0);
    endtask

    task automatic event_cyc(input logic r, input logic j, input logic b, input logic t,
                             input logic s, input logic l, input logic [15:0] a);
        rv = r; jv = j; bv = b; bt = t; seq = s; link = l; tgt = a;
        tick();
        clear_in();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pcwrite", 16'(PCWrite), 16'h0);
        chk("rst_newpc",   newPC, 16'h0000);
        chk("rst_empty",   16'(rasEmpty), 16'h1);
        chk("rst_full",    16'(rasFull), 16'h0);
        chk("rst_err",     16'(err), 16'h0);
        @(negedge CLK) RST_N = 1;

        // sequential
        fetch_instr(16'h0010);
        chk("seq_value", newPC, 16'h0012);
        event_cyc(0, 0, 0, 0, 1, 0, 16'h0);
        chk("seq_nowrite", 16'(PCWrite), 16'h0);
        tick();

        // branch taken / not taken
        fetch_instr(16'h0020);
        event_cyc(0, 0, 1, 1, 0, 0, 16'h0100);
        chk("br_taken", newPC, 16'h0100);
        fetch_instr(16'h0020);
        event_cyc(0, 0, 1, 0, 0, 0, 16'h0100);
        chk("br_nt_pcw", 16'(PCWrite), 16'h0);
        chk("br_nt_val", newPC, 16'h0022);

        // call / return
        fetch_instr(16'h0040);
        event_cyc(0, 1, 0, 0, 0, 1, 16'h0200);
        chk("call_tgt", newPC, 16'h0200);
        chk("call_nonempty", 16'(rasEmpty), 16'h0);
        fetch_instr(16'h0200);
        event_cyc(1, 0, 0, 0, 0, 0, 16'h0);
        chk("ret_val", newPC, 16'h0042);
        chk("ret_empty", 16'(rasEmpty), 16'h1);

        // overflow then underflow
        for (int i = 0; i < 5; i++) begin
            fetch_instr(16'h1000 + 16'(i * 16));
            event_cyc(0, 1, 0, 0, 0, 1, 16'h3000);
        end
        chk("ovf_full", 16'(rasFull), 16'h1);
        chk("ovf_err", 16'(err), 16'h1);
        for (int k = 0; k < 4; k++) begin
            fetch_instr(16'h3000);
            event_cyc(1, 0, 0, 0, 0, 0, 16'h0);
            chk("lifo_val", newPC, 16'h1042 - 16'(k * 16));
        end
        fetch_instr(16'h3000);
        event_cyc(1, 0, 0, 0, 0, 0, 16'h0);
        chk("unf_nowrite", 16'(PCWrite), 16'h0);
        chk("unf_empty", 16'(rasEmpty), 16'h1);

        // priority: return beats jump+link and branch, no push
        fetch_instr(16'h0500);
        event_cyc(0, 1, 0, 0, 0, 1, 16'h0700);
        fetch_instr(16'h0700);
        event_cyc(1, 1, 1, 1, 0, 1, 16'h0900);
        chk("prio_val", newPC, 16'h0502);
        chk("prio_empty", 16'(rasEmpty), 16'h1);

        // stall holds a pending jump
        fetch_instr(16'h0050);
        stall = 1; jv = 1; tgt = 16'h0600;
        repeat (3) begin
            tick();
            chk("stall_nopulse", 16'(PCWrite), 16'h0);
        end
        stall = 0;
        tick();
        chk("stall_release", 16'(PCWrite), 16'h1);
        chk("stall_tgt", newPC, 16'h0600);
        clear_in();

        // wrap
        fetch_instr(16'hFFFE);
        chk("wrap", newPC, 16'h0000);
        event_cyc(0, 0, 0, 0, 1, 0, 16'h0);

        // async reset during a pulse, after loading the RAS
        fetch_instr(16'h0060);
        event_cyc(0, 1, 0, 0, 0, 1, 16'h0080);
        fetch = 1; cur = 16'h0070;
        tick();
        fetch = 0;
        chk("pre_rst_pulse", 16'(PCWrite), 16'h1);
        #2 RST_N = 0;
        #1;
        model_reset();
        chk("arst_pcwrite", 16'(PCWrite), 16'h0);
        chk("arst_newpc", newPC, 16'h0000);
        chk("arst_empty", 16'(rasEmpty), 16'h1);
        chk("arst_err", 16'(err), 16'h0);
        @(negedge CLK) RST_N = 1;

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            fetch = 1'($urandom);
            seq   = ($urandom_range(0, 2) == 0);
            bv    = ($urandom_range(0, 3) == 0);
            bt    = 1'($urandom);
            jv    = ($urandom_range(0, 3) == 0);
            link  = ($urandom_range(0, 2) != 0);
            rv    = ($urandom_range(0, 3) == 0);
            cur   = 16'($urandom);
            tgt   = 16'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
